// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
//
// Fetch-stage branch predictor built from a direct-mapped branch target buffer.
// Each entry holds a valid bit, a tag, a target address, and a 2-bit saturating
// direction counter. The table is looked up combinationally with PCF every
// cycle. It is trained by branches that resolve in Execute. The fetch-stage
// prediction travels with its instruction through a small F->D->E register
// chain, so Execute can compare it against the resolved direction.
//
// Ports
//   clk               in   1   rising-edge clock
//   reset             in   1   asynchronous, active-high reset
//   PCF               in   32  fetch PC
//   StallF            in   1   fetch stall (lookup is combinational, no state effect)
//   StallD            in   1   hold the F->D prediction register
//   FlushD            in   1   clear the F->D prediction register (wins over StallD)
//   FlushE            in   1   clear the D->E prediction register
//   BranchE           in   1   instruction in Execute is a branch
//   BranchTakenE      in   1   resolved direction of that branch
//   PCE               in   32  PC of the instruction in Execute
//   BranchTargetE     in   32  resolved branch target
//   BranchPredicted   out  1   fetch-stage prediction: taken
//   BTA               out  32  predicted target for PCF (0 on miss)
//   BranchPredictedE  out  1   prediction carried with the instruction in Execute
// -----------------------------------------------------------------------------
module branch_target_predictor #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = 3,
   parameter int TAG_W   = 27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        FlushE,
   input  logic        BranchE,
   input  logic        BranchTakenE,
   input  logic [31:0] PCE,
   input  logic [31:0] BranchTargetE,
   output logic        BranchPredicted,
   output logic [31:0] BTA,
   output logic        BranchPredictedE
);

   // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   localparam logic [1:0] CTR_RESET = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [31:0]       r_target [ENTRIES];
   logic [1:0]        r_ctr    [ENTRIES];
   logic              r_pred_d;
   logic              r_pred_e;

   logic [IDX_W-1:0]  w_idx_f;
   logic [TAG_W-1:0]  w_tag_f;
   logic              w_hit_f;
   logic [IDX_W-1:0]  w_idx_e;
   logic [TAG_W-1:0]  w_tag_e;
   logic              w_hit_e;

   // The lookup ignores the fetch stall, and instructions are word aligned,
   // so these bits carry no information for the predictor.
   logic              w_unused;
   assign w_unused = &{1'b0, StallF, PCF[1:0], PCE[1:0]};

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   // ---------------------------------------------------------------- lookup
   assign w_idx_f = PCF[IDX_W+1:2];
   assign w_tag_f = PCF[31:IDX_W+2];
   assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

   // The lookup reads the registered table directly. A same-cycle update to the
   // same entry is therefore seen only from the next cycle; there is no bypass.
   assign BranchPredicted  = w_hit_f && r_ctr[w_idx_f][1];
   assign BTA              = w_hit_f ? r_target[w_idx_f] : 32'b0;
   assign BranchPredictedE = r_pred_e;

   // ---------------------------------------------------------------- training
   assign w_idx_e = PCE[IDX_W+1:2];
   assign w_tag_e = PCE[31:IDX_W+2];
   assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

   // NOTE: the table is a plain register array, so it can take the async reset.
   // Every entry must come up invalid with a weak-NT counter, so each field is
   // reset explicitly. A RAM macro could not be cleared this way.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_RESET;
         end
      end else if (BranchE) begin
         // NOTE: state updates use non-blocking assignments, so every read in
         // this cycle sees the pre-edge contents of the table.
         if (w_hit_e) begin
            if (BranchTakenE) begin
               r_ctr[w_idx_e]    <= sat_inc(r_ctr[w_idx_e]);
               r_target[w_idx_e] <= BranchTargetE;
            end else begin
               r_ctr[w_idx_e]    <= sat_dec(r_ctr[w_idx_e]);
            end
         end else if (BranchTakenE) begin
            // A taken branch that misses claims the slot, even if another
            // branch that aliases to this index currently owns it.
            r_valid[w_idx_e]  <= 1'b1;
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= BranchTargetE;
            r_ctr[w_idx_e]    <= CTR_ALLOC;
         end
      end
   end

   // ---------------------------------------------------------------- F->D->E
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pred_d <= 1'b0;
         r_pred_e <= 1'b0;
      end else begin
         if (FlushD)       r_pred_d <= 1'b0;
         else if (!StallD) r_pred_d <= BranchPredicted;

         r_pred_e <= FlushE ? 1'b0 : r_pred_d;
      end
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Directed bench for branch_target_predictor. A reference model describes the
// table as "which branch word owns each set", with an integer confidence from
// 0 to 3 for each set. It also tracks the prediction that travels with each
// pipeline slot. Every falling edge, the DUT outputs are compared against this
// model. Literal expectations at key points tie the model to hand-derived
// values.
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic        StallF, StallD, FlushD, FlushE;
   logic        BranchE, BranchTakenE;
   logic [31:0] PCE, BranchTargetE;
   logic        BranchPredicted;
   logic [31:0] BTA;
   logic        BranchPredictedE;

   int n_cmp = 0;
   int n_bad = 0;
   bit en_cmp = 1'b0;

   branch_target_predictor #(.ENTRIES(8), .IDX_W(3), .TAG_W(27)) dut (
      .clk              (clk),
      .reset            (reset),
      .PCF              (PCF),
      .StallF           (StallF),
      .StallD           (StallD),
      .FlushD           (FlushD),
      .FlushE           (FlushE),
      .BranchE          (BranchE),
      .BranchTakenE     (BranchTakenE),
      .PCE              (PCE),
      .BranchTargetE    (BranchTargetE),
      .BranchPredicted  (BranchPredicted),
      .BTA              (BTA),
      .BranchPredictedE (BranchPredictedE)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------ model
   bit          m_valid [N];
   logic [31:0] m_word  [N];   // word address (PC>>2) of the owning branch
   logic [31:0] m_tgt   [N];
   int          m_conf  [N];   // 0..3, taken when >= 2
   bit          m_pred_d, m_pred_e;

   function automatic int set_of(logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[set_of(pc)] && (m_word[set_of(pc)] == (pc >> 2));
   endfunction

   function automatic bit m_taken(logic [31:0] pc);
      return m_hit(pc) && (m_conf[set_of(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_target(logic [31:0] pc);
      return m_hit(pc) ? m_tgt[set_of(pc)] : 32'h0;
   endfunction

   always @(posedge clk or posedge reset) begin : model
      bit p_now;
      int s;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_word[i] = '0; m_tgt[i] = '0; m_conf[i] = 1;
         end
         m_pred_d = 1'b0;
         m_pred_e = 1'b0;
      end else begin
         p_now    = m_taken(PCF);
         m_pred_e = FlushE ? 1'b0 : m_pred_d;
         if (FlushD)       m_pred_d = 1'b0;
         else if (!StallD) m_pred_d = p_now;
         if (BranchE) begin
            s = set_of(PCE);
            if (m_hit(PCE)) begin
               if (BranchTakenE) begin
                  m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
                  m_tgt[s]  = BranchTargetE;
               end else begin
                  m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
               end
            end else if (BranchTakenE) begin
               m_valid[s] = 1'b1;
               m_word[s]  = PCE >> 2;
               m_tgt[s]   = BranchTargetE;
               m_conf[s]  = 2;
            end
         end
      end
   end

   // ------------------------------------------------------------ compare
   always @(negedge clk) begin
      if (en_cmp) begin
         check("cyc_pred",   {31'b0, BranchPredicted},  {31'b0, m_taken(PCF)});
         check("cyc_bta",    BTA,                       m_target(PCF));
         check("cyc_pred_e", {31'b0, BranchPredictedE}, {31'b0, m_pred_e});
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      BranchE = 1'b1; BranchTakenE = taken; PCE = pc; BranchTargetE = tgt;
   endtask

   task automatic no_upd();
      BranchE = 1'b0; BranchTakenE = 1'b0; PCE = '0; BranchTargetE = '0;
   endtask

   // Apply one cycle of training, then settle and check the fetch lookup.
   task automatic train_and_check(input string name, input logic [31:0] pc, input bit taken,
                                  input logic [31:0] tgt, input bit exp_p,
                                  input logic [31:0] exp_bta);
      upd(pc, taken, tgt);
      PCF = pc;
      tick();
      no_upd();
      #1;
      check({name, "_pred"}, {31'b0, BranchPredicted}, {31'b0, exp_p});
      check({name, "_bta"},  BTA, exp_bta);
   endtask

   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] tgt;
   } vec_t;

   vec_t vecs[10] = '{
      '{32'h0000_0004, 1'b1, 32'h0000_0080},
      '{32'h0000_0004, 1'b1, 32'h0000_0084},
      '{32'h0000_0024, 1'b1, 32'h0000_0090},   // aliases set 1
      '{32'h0000_0004, 1'b0, 32'h0000_0000},   // not-taken miss
      '{32'h0000_0008, 1'b0, 32'h0000_0000},   // not-taken miss on empty set
      '{32'h0000_001C, 1'b1, 32'hFFFF_FFFC},
      '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010},   // aliases set 7, max tag
      '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000},
      '{32'h0000_0024, 1'b0, 32'h0000_0000},
      '{32'h0000_0024, 1'b0, 32'h0000_0000}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      PCF = 32'h100;
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      no_upd();
      repeat (2) tick();
      check("rst_pred",   {31'b0, BranchPredicted},  32'd0);
      check("rst_bta",    BTA,                       32'd0);
      check("rst_pred_e", {31'b0, BranchPredictedE}, 32'd0);
      reset = 1'b0;
      en_cmp = 1'b1;

      // 1: cold lookups miss; E-stage prediction stays 0
      for (int i = 0; i < 3; i++) begin
         tick();
         check("cold_pred_e", {31'b0, BranchPredictedE}, 32'd0);
         check("cold_pred",   {31'b0, BranchPredicted},  32'd0);
      end

      // 2: allocate on taken miss
      train_and_check("alloc", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      // 3: not taken -> weak-NT, target retained
      train_and_check("nt1", 32'h100, 1'b0, 32'h0, 1'b0, 32'h200);
      train_and_check("t1",  32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      train_and_check("t2",  32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      train_and_check("t3",  32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      train_and_check("t4",  32'h100, 1'b1, 32'h204, 1'b1, 32'h204);
      // saturated at strong-T: one not-taken still predicts taken
      train_and_check("sat_nt1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h204);
      train_and_check("sat_nt2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h204);
      train_and_check("sat_nt3", 32'h100, 1'b0, 32'h0, 1'b0, 32'h204);
      train_and_check("sat_nt4", 32'h100, 1'b0, 32'h0, 1'b0, 32'h204);
      // one taken from strong-NT only reaches weak-NT
      train_and_check("floor_t", 32'h100, 1'b1, 32'h208, 1'b0, 32'h208);

      // 4: alias replacement
      train_and_check("alias", 32'h120, 1'b1, 32'h300, 1'b1, 32'h300);
      PCF = 32'h100; #1;
      check("alias_old_pred", {31'b0, BranchPredicted}, 32'd0);
      check("alias_old_bta",  BTA, 32'd0);
      upd(32'h100, 1'b0, 32'h0);
      tick();
      no_upd();
      PCF = 32'h120; #1;
      check("nt_miss_keep_pred", {31'b0, BranchPredicted}, 32'd1);
      check("nt_miss_keep_bta",  BTA, 32'h300);

      // 5: pipeline latency, stall, flush
      PCF = 32'h40;  repeat (3) tick();
      PCF = 32'h120; tick();              // cycle n
      PCF = 32'h40;  #1;
      check("lat_n1", {31'b0, BranchPredictedE}, 32'd0);
      tick(); check("lat_n2", {31'b0, BranchPredictedE}, 32'd1);
      tick(); check("lat_n3", {31'b0, BranchPredictedE}, 32'd0);

      PCF = 32'h120; tick();              // n
      PCF = 32'h40; StallD = 1'b1; tick();
      StallD = 1'b0;
      check("stall_n2", {31'b0, BranchPredictedE}, 32'd1);
      tick(); check("stall_n3", {31'b0, BranchPredictedE}, 32'd1);
      tick(); check("stall_n4", {31'b0, BranchPredictedE}, 32'd0);

      PCF = 32'h120; FlushD = 1'b1; StallD = 1'b1; tick();   // flush wins
      FlushD = 1'b0; StallD = 1'b0; PCF = 32'h40; tick();
      check("flushd_n2", {31'b0, BranchPredictedE}, 32'd0);

      PCF = 32'h120; tick();
      PCF = 32'h40; FlushE = 1'b1; tick();
      FlushE = 1'b0;
      check("flushe_n2", {31'b0, BranchPredictedE}, 32'd0);
      tick();

      // 6: same-cycle update and lookup; FlushE does not block training
      PCF = 32'h120; upd(32'h120, 1'b0, 32'h0); FlushE = 1'b1; #1;
      check("same_old_pred", {31'b0, BranchPredicted}, 32'd1);
      tick();
      no_upd(); FlushE = 1'b0; #1;
      check("same_new_pred", {31'b0, BranchPredicted}, 32'd0);
      check("same_new_bta",  BTA, 32'h300);

      // table of directed vectors, lookup on the same PC each cycle
      for (int i = 0; i < 10; i++) begin
         upd(vecs[i].pc, vecs[i].taken, vecs[i].tgt);
         PCF = vecs[i].pc;
         tick();
      end
      no_upd();
      for (int i = 0; i < 10; i++) begin
         PCF = vecs[i].pc;
         tick();
      end
      PCF = 32'h1C; #1;
      check("vec_set7_miss", {31'b0, BranchPredicted}, 32'd0);
      PCF = 32'hFFFF_FFFC; #1;
      check("vec_set7_bta", BTA, 32'h10);
      PCF = 32'h24; #1;
      check("vec_set1_pred", {31'b0, BranchPredicted}, 32'd0);
      check("vec_set1_bta",  BTA, 32'h90);

      // asynchronous reset mid-run
      train_and_check("pre_rst", 32'h120, 1'b1, 32'h300, 1'b1, 32'h300);
      PCF = 32'h120; repeat (2) tick();
      reset = 1'b1; #1;
      check("arst_pred",   {31'b0, BranchPredicted},  32'd0);
      check("arst_bta",    BTA,                       32'd0);
      check("arst_pred_e", {31'b0, BranchPredictedE}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_miss", {31'b0, BranchPredicted}, 32'd0);
      PCF = 32'h100; tick();

      en_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
